// File: rtl/intensity_pwm.sv
// intensity_pwm: turns the 4-bit proximity intensity from the distance stage into a
// debounced target level, ramps the drive level one step at a time toward that target,
// and emits a glitch-free PWM whose duty is level/8.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   intensity  in   proximity level 0..8 (9..15 clamp to 8)
//   pwm        out  registered PWM drive
//   level      out  current drive level 0..8
//   target     out  debounced target level 0..8
//   ramping    out  high while level != target
module intensity_pwm #(
    parameter int unsigned SAMPLE_CYCLES = 2400000,
    parameter int unsigned STABLE_COUNT  = 2,
    parameter int unsigned RAMP_CYCLES   = 400000,
    parameter int unsigned PWM_STEP      = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] intensity,
    output logic       pwm,
    output logic [3:0] level,
    output logic [3:0] target,
    output logic       ramping
);

    localparam int unsigned SCW    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int unsigned STW    = $clog2(STABLE_COUNT + 1);
    localparam int unsigned RCW    = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int unsigned PERIOD = 8 * PWM_STEP;
    localparam int unsigned PCW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned DW     = $clog2(PERIOD + 1);

    localparam logic [SCW-1:0] SampleMax = SCW'(SAMPLE_CYCLES - 1);
    localparam logic [STW-1:0] StableMax = STW'(STABLE_COUNT);
    localparam logic [RCW-1:0] RampMax   = RCW'(RAMP_CYCLES - 1);
    localparam logic [PCW-1:0] PeriodMax = PCW'(PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StUp,
        StDown
    } ramp_state_e;

    ramp_state_e ramp_state;

    logic [SCW-1:0] sample_cnt_q, sample_cnt_d;
    logic [3:0]     cand_q, cand_d;
    logic [STW-1:0] stable_q, stable_d;
    logic [3:0]     target_q, target_d;
    logic [RCW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [3:0]     level_q, level_d;
    logic [PCW-1:0] period_cnt_q, period_cnt_d;
    logic [DW-1:0]  duty_q, duty_d;
    logic           pwm_q, pwm_d;

    logic [3:0]     sample;
    logic           tick;
    logic [DW-1:0]  level_duty;
    logic [DW-1:0]  duty_eff;

    assign sample = (intensity > 4'd8) ? 4'd8 : intensity;
    assign tick   = (sample_cnt_q == SampleMax);

    // Sample timebase and debounce.
    always_comb begin
        sample_cnt_d = tick ? '0 : sample_cnt_q + SCW'(1);
        cand_d       = cand_q;
        stable_d     = stable_q;
        target_d     = target_q;
        if (tick) begin
            if (sample == cand_q) begin
                if (stable_q != StableMax) begin
                    stable_d = stable_q + STW'(1);
                end
            end else begin
                cand_d   = sample;
                stable_d = STW'(1);
            end
            if (stable_d == StableMax) begin
                target_d = cand_d;
            end
        end
    end

    // Ramp FSM: the state is purely a decode of level vs target, so a target change takes
    // effect on the very next cycle without disturbing the running step counter.
    always_comb begin
        if (level_q < target_q) begin
            ramp_state = StUp;
        end else if (level_q > target_q) begin
            ramp_state = StDown;
        end else begin
            ramp_state = StIdle;
        end
    end

    always_comb begin
        ramp_cnt_d = '0;
        level_d    = level_q;
        unique case (ramp_state)
            StIdle: ramp_cnt_d = '0;
            StUp, StDown: begin
                if (ramp_cnt_q == RampMax) begin
                    ramp_cnt_d = '0;
                    level_d    = (ramp_state == StUp) ? level_q + 4'd1 : level_q - 4'd1;
                end else begin
                    ramp_cnt_d = ramp_cnt_q + RCW'(1);
                end
            end
            default: ramp_cnt_d = '0;
        endcase
    end

    // PWM. The duty for a new period is taken from level at counter 0 and also used for the
    // compare on that same cycle, so full-scale stays high across the wrap and zero stays low.
    assign level_duty = DW'(level_q) * DW'(PWM_STEP);
    assign duty_eff   = (period_cnt_q == '0) ? level_duty : duty_q;

    always_comb begin
        period_cnt_d = (period_cnt_q == PeriodMax) ? '0 : period_cnt_q + PCW'(1);
        duty_d       = duty_eff;
        pwm_d        = (DW'(period_cnt_q) < duty_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt_q <= '0;
            cand_q       <= '0;
            stable_q     <= '0;
            target_q     <= '0;
            ramp_cnt_q   <= '0;
            level_q      <= '0;
            period_cnt_q <= '0;
            duty_q       <= '0;
            pwm_q        <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            cand_q       <= cand_d;
            stable_q     <= stable_d;
            target_q     <= target_d;
            ramp_cnt_q   <= ramp_cnt_d;
            level_q      <= level_d;
            period_cnt_q <= period_cnt_d;
            duty_q       <= duty_d;
            pwm_q        <= pwm_d;
        end
    end

    assign pwm     = pwm_q;
    assign level   = level_q;
    assign target  = target_q;
    assign ramping = (ramp_state != StIdle);

endmodule
